// File: rtl/distributor81.sv
// Registered 1-to-8 distributor: a valid/ready write lands in one of eight
// holding slots, each flagged until acknowledged; refused writes are counted.
module distributor81 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iD,
   input  logic        iS2,
   input  logic        iS1,
   input  logic        iS0,
   input  logic        iValid,
   output logic        oReady,
   input  logic [7:0]  iAck,
   output logic [31:0] oZ0,
   output logic [31:0] oZ1,
   output logic [31:0] oZ2,
   output logic [31:0] oZ3,
   output logic [31:0] oZ4,
   output logic [31:0] oZ5,
   output logic [31:0] oZ6,
   output logic [31:0] oZ7,
   output logic [7:0]  oV,
   output logic [7:0]  oDrop
);

   logic [2:0]  sel;
   logic [31:0] slotData [8];
   logic [7:0]  vNext;
   logic        accept;
   logic        refuse;

   assign sel    = {iS2, iS1, iS0};
   // A slot being released this cycle can take new data on the same edge.
   assign oReady = ~oV[sel] | iAck[sel];
   assign accept = iValid & oReady;
   assign refuse = iValid & ~oReady;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) slotData[i] <= '0;
      end else if (accept) begin
         slotData[sel] <= iD;
      end
   end

   // Acks clear first, then the write sets its flag, so write beats ack.
   always_comb begin
      vNext = oV & ~iAck;
      if (accept) vNext[sel] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) oV <= '0;
      else     oV <= vNext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          oDrop <= '0;
      else if (refuse && oDrop != '1)   oDrop <= oDrop + 8'd1;
   end

   assign oZ0 = slotData[0];
   assign oZ1 = slotData[1];
   assign oZ2 = slotData[2];
   assign oZ3 = slotData[3];
   assign oZ4 = slotData[4];
   assign oZ5 = slotData[5];
   assign oZ6 = slotData[6];
   assign oZ7 = slotData[7];

endmodule

// File: tb/tb_distributor81.sv
// Bench for distributor81: directed cases with literal expectations plus
// random traffic, all checked every cycle against a slot-level model.
module tb_distributor81;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] iD = '0;
   logic [2:0]  selIn = '0;
   logic        iValid = 1'b0;
   logic        oReady;
   logic [7:0]  iAck = '0;
   logic [31:0] oZ0, oZ1, oZ2, oZ3, oZ4, oZ5, oZ6, oZ7;
   logic [7:0]  oV;
   logic [7:0]  oDrop;

   int checks = 0;
   int failures = 0;

   logic [31:0] mZ [8];
   logic [7:0]  mV;
   int          mDrop;

   always #5 clk = ~clk;

   distributor81 dut (
      .clk(clk), .rst(rst), .iD(iD),
      .iS2(selIn[2]), .iS1(selIn[1]), .iS0(selIn[0]),
      .iValid(iValid), .oReady(oReady), .iAck(iAck),
      .oZ0(oZ0), .oZ1(oZ1), .oZ2(oZ2), .oZ3(oZ3),
      .oZ4(oZ4), .oZ5(oZ5), .oZ6(oZ6), .oZ7(oZ7),
      .oV(oV), .oDrop(oDrop)
   );

   function automatic logic [31:0] getZ(input int k);
      case (k)
         0: return oZ0;
         1: return oZ1;
         2: return oZ2;
         3: return oZ3;
         4: return oZ4;
         5: return oZ5;
         6: return oZ6;
         default: return oZ7;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelClear();
      for (int k = 0; k < 8; k++) mZ[k] = '0;
      mV = '0;
      mDrop = 0;
   endtask

   task automatic setIn(input logic v, input int s, input logic [31:0] d, input logic [7:0] a);
      iValid = v;
      selIn  = 3'(s);
      iD     = d;
      iAck   = a;
   endtask

   // Model: a write succeeds if the slot is empty or being acked; acks
   // release flags; a refused write bumps the drop count up to 255.
   task automatic tick();
      bit ok;
      @(posedge clk);
      if (!rst) begin
         ok = iValid && (!mV[selIn] || iAck[selIn]);
         mV = mV & ~iAck;
         if (ok) begin
            mZ[selIn] = iD;
            mV[selIn] = 1'b1;
         end else if (iValid && mDrop < 255) begin
            mDrop++;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input int s, input logic [31:0] d, input logic [7:0] a);
      setIn(v, s, d, a);
      tick();
   endtask

   always @(negedge clk) begin
      chk("cyc_ready", {31'b0, oReady}, {31'b0, ~mV[selIn] | iAck[selIn]});
      chk("cyc_v", {24'b0, oV}, {24'b0, mV});
      chk("cyc_drop", {24'b0, oDrop}, 32'(mDrop));
      for (int k = 0; k < 8; k++) chk($sformatf("cyc_z%0d", k), getZ(k), mZ[k]);
   end

   initial begin
      modelClear();
      drive(1'b1, 2, 32'h12345678, 8'h00);
      drive(1'b0, 0, 32'h0, 8'h00);
      rst = 1'b0;
      chk("rst_v", {24'b0, oV}, 32'h0);
      chk("rst_drop", {24'b0, oDrop}, 32'h0);
      chk("rst_z2", oZ2, 32'h0);

      for (int k = 0; k < 8; k++) drive(1'b1, k, 32'hA0000000 + 32'(k), 8'h00);
      chk("fill_v", {24'b0, oV}, 32'hFF);
      for (int k = 0; k < 8; k++) chk($sformatf("fill_z%0d", k), getZ(k), 32'hA0000000 + 32'(k));

      setIn(1'b1, 3, 32'hDEADBEEF, 8'h00);
      #1;
      chk("refuse_ready", {31'b0, oReady}, 32'h0);
      tick();
      chk("refuse_z3", oZ3, 32'hA0000003);
      chk("refuse_drop1", {24'b0, oDrop}, 32'h1);
      for (int i = 0; i < 4; i++) drive(1'b1, 3, 32'hDEADBEEF, 8'h00);
      chk("refuse_drop5", {24'b0, oDrop}, 32'h5);

      drive(1'b1, 5, 32'h11111111, 8'h20);
      setIn(1'b1, 5, 32'h22222222, 8'h20);
      #1;
      chk("wack_ready", {31'b0, oReady}, 32'h1);
      tick();
      chk("wack_z5", oZ5, 32'h22222222);
      chk("wack_v5", {31'b0, oV[5]}, 32'h1);
      chk("wack_drop", {24'b0, oDrop}, 32'h5);

      drive(1'b1, 2, 32'h5, 8'h81);
      chk("par_v", {24'b0, oV}, 32'h7E);
      chk("par_z2", oZ2, 32'hA0000002);
      chk("par_drop", {24'b0, oDrop}, 32'h6);
      drive(1'b0, 0, 32'h0, 8'h04);
      chk("par_v2", {24'b0, oV}, 32'h7A);
      chk("par_z0", oZ0, 32'hA0000000);
      chk("par_z7", oZ7, 32'hA0000007);

      for (int i = 0; i < 300; i++) drive(1'b1, 3, 32'hDEADBEEF, 8'h00);
      chk("sat_drop", {24'b0, oDrop}, 32'hFF);
      drive(1'b1, 4, 32'hDEADBEEF, 8'h00);
      chk("sat_hold", {24'b0, oDrop}, 32'hFF);

      setIn(1'b1, 3, 32'hCAFEF00D, 8'h00);
      #2;
      rst = 1'b1;
      modelClear();
      #1;
      chk("arst_v", {24'b0, oV}, 32'h0);
      chk("arst_drop", {24'b0, oDrop}, 32'h0);
      chk("arst_z3", oZ3, 32'h0);
      chk("arst_ready", {31'b0, oReady}, 32'h1);
      tick();
      tick();
      chk("arst_hold_v", {24'b0, oV}, 32'h0);
      rst = 1'b0;

      drive(1'b0, 0, 32'h0, 8'hFF);
      chk("spur_v", {24'b0, oV}, 32'h0);
      drive(1'b1, 6, 32'h66666666, 8'h00);
      chk("spur_v6", {24'b0, oV}, 32'h40);
      chk("spur_z6", oZ6, 32'h66666666);

      for (int i = 0; i < 3000; i++) begin
         if (i % 997 == 500) begin
            rst = 1'b1;
            modelClear();
            tick();
            rst = 1'b0;
         end
         drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), $urandom,
               8'($urandom & $urandom & $urandom));
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
